// File: rtl/arc4_pkg.sv
// Shared ARC4 types: byte type, PRGA state encoding and printable-ASCII bounds
// used by the optional plaintext check in prga.
package arc4_pkg;

    typedef logic [7:0] byte_t;

    localparam byte_t ASCII_LO = 8'h20;
    localparam byte_t ASCII_HI = 8'h7E;

    typedef enum logic [3:0] {
        IDLE,
        RD_LEN,
        WAIT_LEN,
        WR_LEN,
        RD_SI,
        WAIT_SI,
        RD_SJ,
        WAIT_SJ,
        WR_SJ,
        WR_SI,
        RD_PAD,
        WAIT_PAD,
        WR_PT,
        NEXT,
        DONE
    } prga_state_e;

    function automatic logic is_printable(byte_t b);
        return (b >= ASCII_LO) && (b <= ASCII_HI);
    endfunction

endpackage

// File: rtl/prga.sv
// ARC4 keystream generator / decryptor over an S array prepared by ksa.
// Define PRGA_ASCII_CHECK_EN to flag non-printable plaintext and stop early.
module prga
    import arc4_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    output logic       rdy,
    output logic [7:0] s_addr,
    input  logic [7:0] s_rddata,
    output logic [7:0] s_wrdata,
    output logic       s_wren,
    output logic [7:0] ct_addr,
    input  logic [7:0] ct_rddata,
    output logic [7:0] pt_addr,
    output logic [7:0] pt_wrdata,
    output logic       pt_wren,
    output logic       bad
);

    prga_state_e state_q, state_d;

    byte_t i_q, i_d;
    byte_t j_q, j_d;
    byte_t k_q, k_d;
    byte_t len_q, len_d;
    byte_t si_q, si_d;
    byte_t sj_q, sj_d;
    logic  last_q, last_d;
    logic  nph_q, nph_d;

    // Memory-side outputs are registered: every state holds its address on
    // the port for its whole cycle, so the wait states see a stable address.
    byte_t s_addr_q, s_addr_d;
    byte_t s_wrdata_q, s_wrdata_d;
    logic  s_wren_q, s_wren_d;
    byte_t ct_addr_q, ct_addr_d;
    byte_t pt_addr_q, pt_addr_d;
    byte_t pt_wrdata_q, pt_wrdata_d;
    logic  pt_wren_q, pt_wren_d;

`ifdef PRGA_ASCII_CHECK_EN
    logic bad_q, bad_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            i_q         <= '0;
            j_q         <= '0;
            k_q         <= '0;
            len_q       <= '0;
            si_q        <= '0;
            sj_q        <= '0;
            last_q      <= 1'b0;
            nph_q       <= 1'b0;
            s_addr_q    <= '0;
            s_wrdata_q  <= '0;
            s_wren_q    <= 1'b0;
            ct_addr_q   <= '0;
            pt_addr_q   <= '0;
            pt_wrdata_q <= '0;
            pt_wren_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            j_q         <= j_d;
            k_q         <= k_d;
            len_q       <= len_d;
            si_q        <= si_d;
            sj_q        <= sj_d;
            last_q      <= last_d;
            nph_q       <= nph_d;
            s_addr_q    <= s_addr_d;
            s_wrdata_q  <= s_wrdata_d;
            s_wren_q    <= s_wren_d;
            ct_addr_q   <= ct_addr_d;
            pt_addr_q   <= pt_addr_d;
            pt_wrdata_q <= pt_wrdata_d;
            pt_wren_q   <= pt_wren_d;
        end
    end

`ifdef PRGA_ASCII_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bad_q <= 1'b0;
        else        bad_q <= bad_d;
    end
`endif

    always_comb begin
        state_d     = state_q;
        i_d         = i_q;
        j_d         = j_q;
        k_d         = k_q;
        len_d       = len_q;
        si_d        = si_q;
        sj_d        = sj_q;
        last_d      = last_q;
        nph_d       = nph_q;
        s_addr_d    = s_addr_q;
        s_wrdata_d  = s_wrdata_q;
        s_wren_d    = 1'b0;
        ct_addr_d   = ct_addr_q;
        pt_addr_d   = pt_addr_q;
        pt_wrdata_d = pt_wrdata_q;
        pt_wren_d   = 1'b0;
`ifdef PRGA_ASCII_CHECK_EN
        bad_d       = bad_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (en) begin
                    state_d   = RD_LEN;
                    i_d       = '0;
                    j_d       = '0;
                    k_d       = '0;
                    nph_d     = 1'b0;
                    ct_addr_d = '0;
`ifdef PRGA_ASCII_CHECK_EN
                    bad_d     = 1'b0;
`endif
                end
            end
            RD_LEN: state_d = WAIT_LEN;
            WAIT_LEN: begin
                state_d     = WR_LEN;
                len_d       = ct_rddata;
                pt_wren_d   = 1'b1;
                pt_addr_d   = '0;
                pt_wrdata_d = ct_rddata;
            end
            WR_LEN: begin
                if (len_q == '0) begin
                    state_d = DONE;
                end else begin
                    state_d  = RD_SI;
                    k_d      = 8'd1;
                    i_d      = i_q + 8'd1;
                    s_addr_d = i_q + 8'd1;
                end
            end
            RD_SI: state_d = WAIT_SI;
            WAIT_SI: begin
                state_d  = RD_SJ;
                si_d     = s_rddata;
                j_d      = j_q + s_rddata;
                s_addr_d = j_q + s_rddata;
            end
            RD_SJ: state_d = WAIT_SJ;
            // Both swap operands are latched before either write is issued,
            // so the swap never reads a half-updated pair.
            WAIT_SJ: begin
                state_d    = WR_SJ;
                sj_d       = s_rddata;
                s_wren_d   = 1'b1;
                s_addr_d   = j_q;
                s_wrdata_d = si_q;
            end
            WR_SJ: begin
                state_d    = WR_SI;
                s_wren_d   = 1'b1;
                s_addr_d   = i_q;
                s_wrdata_d = sj_q;
            end
            WR_SI: begin
                state_d   = RD_PAD;
                s_addr_d  = si_q + sj_q;
                ct_addr_d = k_q;
            end
            RD_PAD: state_d = WAIT_PAD;
            WAIT_PAD: begin
                state_d     = WR_PT;
                pt_wren_d   = 1'b1;
                pt_addr_d   = k_q;
                pt_wrdata_d = s_rddata ^ ct_rddata;
            end
            WR_PT: begin
                state_d = NEXT;
`ifdef PRGA_ASCII_CHECK_EN
                if (!is_printable(pt_wrdata_q)) begin
                    bad_d   = 1'b1;
                    state_d = DONE;
                end
`endif
            end
            // Two cycles: the k==L compare is registered first, then acted on,
            // so k is only incremented when it is known not to be the last byte.
            NEXT: begin
                if (!nph_q) begin
                    nph_d  = 1'b1;
                    last_d = (k_q == len_q);
                end else begin
                    nph_d = 1'b0;
                    if (last_q) begin
                        state_d = DONE;
                    end else begin
                        state_d  = RD_SI;
                        k_d      = k_q + 8'd1;
                        i_d      = i_q + 8'd1;
                        s_addr_d = i_q + 8'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign rdy       = (state_q == IDLE);
    assign s_addr    = s_addr_q;
    assign s_wrdata  = s_wrdata_q;
    assign s_wren    = s_wren_q;
    assign ct_addr   = ct_addr_q;
    assign pt_addr   = pt_addr_q;
    assign pt_wrdata = pt_wrdata_q;
    assign pt_wren   = pt_wren_q;

`ifdef PRGA_ASCII_CHECK_EN
    assign bad = bad_q;
`else
    assign bad = 1'b0;
`endif

endmodule

// File: tb/tb_prga.sv
// Self-checking bench for prga: vector table over identity S, mid-run reset,
// and a full 255-byte run over a bench-computed ksa S array.
module tb_prga;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       rdy;
    logic [7:0] s_addr, s_rddata, s_wrdata;
    logic       s_wren;
    logic [7:0] ct_addr, ct_rddata;
    logic [7:0] pt_addr, pt_wrdata;
    logic       pt_wren;
    logic       bad;

    prga dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy),
        .s_addr(s_addr), .s_rddata(s_rddata), .s_wrdata(s_wrdata), .s_wren(s_wren),
        .ct_addr(ct_addr), .ct_rddata(ct_rddata),
        .pt_addr(pt_addr), .pt_wrdata(pt_wrdata), .pt_wren(pt_wren),
        .bad(bad)
    );

    always #5 clk = ~clk;

    // synchronous-read memories
    logic [7:0] smem[256];
    logic [7:0] s_init[256];
    logic [7:0] ctmem[256];
    bit         s_load = 1'b0;

    always @(posedge clk) begin
        s_rddata  <= smem[s_addr];
        ct_rddata <= ctmem[ct_addr];
        if (s_load) begin
            for (int x = 0; x < 256; x++) smem[x] <= s_init[x];
        end else if (s_wren) begin
            smem[s_addr] <= s_wrdata;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // scoreboard of expected pt writes
    typedef struct packed { logic [7:0] a; logic [7:0] d; } ptw_t;
    ptw_t       exp_q[$];
    ptw_t       mon_e;
    logic [7:0] exp_pt[256];

    always @(negedge clk) begin
        if (s_wren || pt_wren) chk("wren_exclusive", int'(s_wren & pt_wren), 0);
        if (pt_wren) begin
            chk("sb_has_entry", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("pt_addr", int'(pt_addr), int'(mon_e.a));
                chk("pt_data", int'(pt_wrdata), int'(mon_e.d));
            end
        end
    end

    task automatic expect_run(input int len, output int ncyc, output bit nbad);
        exp_q.delete();
        exp_q.push_back({8'd0, len[7:0]});
        ncyc = 4 + 11 * len;
        nbad = 1'b0;
        for (int k = 1; k <= len; k++) begin
            exp_q.push_back({k[7:0], exp_pt[k]});
`ifdef PRGA_ASCII_CHECK_EN
            if (exp_pt[k] < 8'h20 || exp_pt[k] > 8'h7E) begin
                nbad = 1'b1;
                ncyc = 2 + 11 * k;
                break;
            end
`endif
        end
    endtask

    task automatic load_s;
        @(negedge clk);
        s_load = 1'b1;
        @(negedge clk);
        s_load = 1'b0;
    endtask

    task automatic load_identity;
        for (int x = 0; x < 256; x++) s_init[x] = x[7:0];
        load_s();
    endtask

    task automatic start_run(input int hold, output int cyc);
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        chk("rdy_falls", int'(rdy), 0);
        chk("bad_cleared", int'(bad), 0);
        cyc = 0;
        do begin
            if (cyc == hold) en = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end while (!rdy && cyc < 4000);
        en = 1'b0;
        chk("run_terminates", int'(rdy), 1);
        @(negedge clk);
    endtask

    typedef struct {
        logic [7:0] len;
        logic [7:0] c1, c2, c3;
        logic [7:0] p1, p2, p3;
    } vec_t;

    vec_t vecs[8];
    int   cyc, ncyc, n, wr, bad_cnt;
    bit   nbad;
    logic [7:0] ms[256];
    logic [7:0] key[3];
    logic [7:0] mi, mj, tmp, ks, ptc;

    initial begin
        // identity S keystream is 02, 05, 07
        vecs[0] = '{8'd0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        vecs[1] = '{8'd1, 8'h41, 8'h00, 8'h00, 8'h43, 8'h00, 8'h00};
        vecs[2] = '{8'd2, 8'h00, 8'h00, 8'h00, 8'h02, 8'h05, 8'h00};
        vecs[3] = '{8'd3, 8'h41, 8'h41, 8'h41, 8'h43, 8'h44, 8'h46};
        vecs[4] = '{8'd3, 8'h00, 8'h41, 8'h41, 8'h02, 8'h44, 8'h46};
        vecs[5] = '{8'd2, 8'h7C, 8'h25, 8'h00, 8'h7E, 8'h20, 8'h00};
        vecs[6] = '{8'd1, 8'h1D, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};
        vecs[7] = '{8'd1, 8'h7D, 8'h00, 8'h00, 8'h7F, 8'h00, 8'h00};

        for (int x = 0; x < 256; x++) ctmem[x] = 8'h00;

        #12;
        chk("rst_rdy", int'(rdy), 1);
        chk("rst_bad", int'(bad), 0);
        chk("rst_s_wren", int'(s_wren), 0);
        chk("rst_pt_wren", int'(pt_wren), 0);
        chk("rst_s_addr", int'(s_addr), 0);
        chk("rst_s_wrdata", int'(s_wrdata), 0);
        chk("rst_ct_addr", int'(ct_addr), 0);
        chk("rst_pt_addr", int'(pt_addr), 0);
        chk("rst_pt_wrdata", int'(pt_wrdata), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            load_identity();
            ctmem[0] = vecs[v].len;
            ctmem[1] = vecs[v].c1; ctmem[2] = vecs[v].c2; ctmem[3] = vecs[v].c3;
            exp_pt[1] = vecs[v].p1; exp_pt[2] = vecs[v].p2; exp_pt[3] = vecs[v].p3;
            expect_run(int'(vecs[v].len), ncyc, nbad);
            start_run(0, cyc);
            chk("vec_cycles", cyc, ncyc);
            chk("vec_sb_empty", exp_q.size(), 0);
            chk("vec_bad", int'(bad), int'(nbad));
            if (v == 0) begin
                bad_cnt = 0;
                for (int x = 0; x < 256; x++) if (smem[x] !== x[7:0]) bad_cnt++;
                chk("l0_s_unchanged", bad_cnt, 0);
            end
            if (v == 2) begin
`ifdef PRGA_ASCII_CHECK_EN
                chk("swap_s2", int'(smem[2]), 2);
                chk("swap_s3", int'(smem[3]), 3);
`else
                chk("swap_s2", int'(smem[2]), 3);
                chk("swap_s3", int'(smem[3]), 2);
`endif
            end
        end

        // reset at WR_SJ of byte 2 (third S write)
        load_identity();
        ctmem[0] = 8'd2; ctmem[1] = 8'h41; ctmem[2] = 8'h41;
        exp_pt[1] = 8'h43; exp_pt[2] = 8'h44;
        expect_run(2, ncyc, nbad);
        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        n = 0;
        wr = 0;
        while (wr < 3 && n < 200) begin
            @(negedge clk);
            n++;
            if (s_wren) wr++;
        end
        chk("reach_byte2_wr_sj", wr, 3);
        chk("byte2_wr_sj_addr", int'(s_addr), 3);
        rst_n = 1'b0;
        #1;
        chk("abort_rdy", int'(rdy), 1);
        chk("abort_s_wren", int'(s_wren), 0);
        chk("abort_pt_wren", int'(pt_wren), 0);
        chk("abort_s_addr", int'(s_addr), 0);
        chk("abort_bad", int'(bad), 0);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_no_s_write", int'(smem[3]), 3);
        load_identity();
        expect_run(2, ncyc, nbad);
        start_run(0, cyc);
        chk("rerun_cycles", cyc, 26);
        chk("rerun_sb_empty", exp_q.size(), 0);
        chk("rerun_s2", int'(smem[2]), 3);
        chk("rerun_s3", int'(smem[3]), 2);

        // full-length run over a ksa-scheduled S, en held high while busy
        key[0] = 8'h01; key[1] = 8'h23; key[2] = 8'h45;
        for (int x = 0; x < 256; x++) ms[x] = x[7:0];
        mj = 8'd0;
        for (int x = 0; x < 256; x++) begin
            mj = mj + ms[x] + key[x % 3];
            tmp = ms[x]; ms[x] = ms[mj]; ms[mj] = tmp;
        end
        for (int x = 0; x < 256; x++) s_init[x] = ms[x];
        ctmem[0] = 8'd255;
        mi = 8'd0;
        mj = 8'd0;
        for (int k = 1; k <= 255; k++) begin
            mi = mi + 8'd1;
            mj = mj + ms[mi];
            tmp = ms[mi]; ms[mi] = ms[mj]; ms[mj] = tmp;
            tmp = ms[mi] + ms[mj];
            ks = ms[tmp];
            ptc = 8'($urandom_range(32, 126));
            ctmem[k] = ks ^ ptc;
            exp_pt[k] = ptc;
        end
        load_s();
        expect_run(255, ncyc, nbad);
        start_run(20, cyc);
        chk("l255_cycles", cyc, 2809);
        chk("l255_sb_empty", exp_q.size(), 0);
        chk("l255_bad", int'(bad), 0);
        bad_cnt = 0;
        for (int x = 0; x < 256; x++) if (smem[x] !== ms[x]) bad_cnt++;
        chk("l255_final_s", bad_cnt, 0);
        chk("l255_idle_after", int'(rdy), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
